// File: rtl/iic_dsdemod.sv
// Sinc3 (3rd-order CIC) decimator: single-bit delta-sigma stream in, 16-bit unsigned PCM out.
// Optional clip flag output sat_o is enabled by defining IIC_DSDEMOD_SAT_FLAG_EN.
module iic_dsdemod #(
   parameter int DW = 16,
   parameter int AW = 25
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          ds_i,
   input  logic [1:0]    osr_i,
   output logic [DW-1:0] data_o,
   output logic          data_valid_o
`ifdef IIC_DSDEMOD_SAT_FLAG_EN
   ,
   output logic          sat_o
`endif
);

   logic [AW-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
   logic [AW-1:0] i3_prev_q, i3_prev_d, c1_prev_q, c1_prev_d, c2_prev_q, c2_prev_d;
   logic [AW-1:0] c3_q, c3_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [1:0]    settle_q, settle_d;
   logic [1:0]    osr_q, osr_d;
   logic          pend_q, pend_d;
   logic [DW-1:0] data_q, data_d;
   logic          valid_q, valid_d;
`ifdef IIC_DSDEMOD_SAT_FLAG_EN
   logic          sat_q, sat_d;
`endif

   logic [AW-1:0] c1, c2, c3;
   logic [AW:0]   sc;
   logic [7:0]    r_last;
   logic          dec, osr_chg, clip;

   always_comb begin
      i1_d      = i1_q;
      i2_d      = i2_q;
      i3_d      = i3_q;
      i3_prev_d = i3_prev_q;
      c1_prev_d = c1_prev_q;
      c2_prev_d = c2_prev_q;
      c3_d      = c3_q;
      cnt_d     = cnt_q;
      settle_d  = settle_q;
      pend_d    = 1'b0;
      data_d    = data_q;
      valid_d   = 1'b0;
      osr_d     = osr_i;
      c1        = '0;
      c2        = '0;
      c3        = '0;
      sc        = '0;

      case (osr_q)
         2'd0:    r_last = 8'd31;
         2'd1:    r_last = 8'd63;
         2'd2:    r_last = 8'd127;
         default: r_last = 8'd255;
      endcase
      dec     = (cnt_q == r_last);
      osr_chg = (osr_i != osr_q);

      // Map the full-scale comb value R^3 onto 2^16.
      case (osr_q)
         2'd0:    sc = {c3_q, 1'b0};
         2'd1:    sc = {1'b0, c3_q >> 2};
         2'd2:    sc = {1'b0, c3_q >> 5};
         default: sc = {1'b0, c3_q >> 8};
      endcase
      clip = |sc[AW:DW];

`ifdef IIC_DSDEMOD_SAT_FLAG_EN
      sat_d = 1'b0;
`endif

      if (osr_chg) begin
         // Ratio change restarts the filter; data_o keeps its last word.
         i1_d      = '0;
         i2_d      = '0;
         i3_d      = '0;
         i3_prev_d = '0;
         c1_prev_d = '0;
         c2_prev_d = '0;
         c3_d      = '0;
         cnt_d     = '0;
         settle_d  = '0;
      end else begin
         i1_d  = i1_q + {{(AW-1){1'b0}}, ds_i};
         i2_d  = i2_q + i1_q;
         i3_d  = i3_q + i2_q;
         cnt_d = dec ? 8'd0 : cnt_q + 8'd1;
         if (dec) begin
            c1        = i3_q - i3_prev_q;
            c2        = c1 - c1_prev_q;
            c3        = c2 - c2_prev_q;
            i3_prev_d = i3_q;
            c1_prev_d = c1;
            c2_prev_d = c2;
            c3_d      = c3;
            // Comb history is only fully populated from the 4th event on.
            if (settle_q == 2'd3) pend_d = 1'b1;
            else                  settle_d = settle_q + 2'd1;
         end
         if (pend_q) begin
            valid_d = 1'b1;
            data_d  = clip ? {DW{1'b1}} : sc[DW-1:0];
`ifdef IIC_DSDEMOD_SAT_FLAG_EN
            sat_d   = clip;
`endif
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         i1_q      <= '0;
         i2_q      <= '0;
         i3_q      <= '0;
         i3_prev_q <= '0;
         c1_prev_q <= '0;
         c2_prev_q <= '0;
         c3_q      <= '0;
         cnt_q     <= '0;
         settle_q  <= '0;
         osr_q     <= '0;
         pend_q    <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
`ifdef IIC_DSDEMOD_SAT_FLAG_EN
         sat_q     <= 1'b0;
`endif
      end else begin
         i1_q      <= i1_d;
         i2_q      <= i2_d;
         i3_q      <= i3_d;
         i3_prev_q <= i3_prev_d;
         c1_prev_q <= c1_prev_d;
         c2_prev_q <= c2_prev_d;
         c3_q      <= c3_d;
         cnt_q     <= cnt_d;
         settle_q  <= settle_d;
         osr_q     <= osr_d;
         pend_q    <= pend_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
`ifdef IIC_DSDEMOD_SAT_FLAG_EN
         sat_q     <= sat_d;
`endif
      end
   end

   assign data_o       = data_q;
   assign data_valid_o = valid_q;
`ifdef IIC_DSDEMOD_SAT_FLAG_EN
   assign sat_o        = sat_q;
`endif

endmodule

// File: doc/iic_dsdemod.md
Name: iic_dsdemod

Overview:
Sinc3 (3rd-order CIC) decimator that turns a single-bit delta-sigma bitstream back into 16-bit unsigned PCM words. It is the receive-side counterpart of the team's delta-sigma modulator. It runs on the bitstream clock and emits one output word per OSR input bits. It is used in the loopback test path and as the on-chip demodulator for external single-bit ADC streams.

Parameters:
- DW, 16, output word width (fixed at 16; the parameter exists only for documentation and must not be overridden).
- AW, 25, internal integrator/comb width (3*log2(256)+1; must not be reduced).

Ports:
- clk_i  in  1  bitstream clock; one ds_i bit per rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- ds_i  in  1  bitstream input; 1 = +full scale, 0 = zero.
- osr_i  in  2  decimation ratio R: 0=32, 1=64, 2=128, 3=256.
- data_o  out  16  decimated UINT sample, held between strobes.
- data_valid_o  out  1  one-cycle strobe when data_o has just updated.

Behaviour:
- Reset (asynchronous, rst_n_i=0): all integrators, combs, decimation counter and settle counter clear to 0; data_o=16'h0000; data_valid_o=0.
- Integrators: three cascaded AW-bit accumulators update on every clk_i edge. I1+=ds_i, I2+=I1, I3+=I2. Modulo-2^AW wrap-around is intentional and required; there is no saturation inside the CIC.
- Decimation counter: cnt runs 0..R-1 and wraps. On the edge where cnt==R-1, I3 is sampled and the comb pipeline runs. C1=I3-I3_prev, C2=C1-C1_prev, C3=C2-C2_prev, all in modulo-AW arithmetic and computed in that same edge's logic. The comb result registers at that edge.
- Scaling: the full-scale comb value is R^3 = 2^(3*log2R). The output is the comb value shifted so that R^3 maps to 2^16:
  - R=32: shift left by 1.
  - R=64: shift right by 2.
  - R=128: shift right by 5.
  - R=256: shift right by 8.
  - Results above 16'hFFFF saturate to 16'hFFFF (only all-ones input reaches this).
- Output timing: data_o loads the scaled value, and data_valid_o pulses high for exactly one cycle, on the edge after the comb update. Latency from the decimation edge is 1 clk_i. Strobe spacing is exactly R clocks.
- Settling: the first 3 decimation events after reset or after an osr_i change still update internal combs, but do not assert data_valid_o and do not update data_o. The 4th and later events produce valid strobes. The settle counter is 2 bits and saturates.
- osr_i change: osr_i is sampled every clock. Any change from the value registered on the previous clock synchronously clears the integrators, combs, cnt and settle counter on that edge. data_o keeps its old value.
- Reset mid-operation: immediate clear as above. No strobe is issued for a partially accumulated period.
- Simultaneous osr_i change and decimation edge: the clear wins, and no comb update or strobe occurs.

Optional Feature:
- Macro IIC_DSDEMOD_SAT_FLAG_EN.
- Defined: adds output port sat_o (1 bit, reset 0). sat_o is registered alongside data_o and is high for the strobe cycle when the scaled result was clipped to 16'hFFFF; it is 0 otherwise.
- Not defined: no sat_o port exists, clipping still occurs silently, and there is no other difference.

Test Plan:
- Reset, osr_i=0, ds_i=1 constant -> no strobe for the first 3 periods; then data_valid_o pulses every 32 clocks with data_o=16'hFFFF (sat_o=1 if enabled).
- osr_i=3, ds_i alternating 1,0,1,0 -> strobes every 256 clocks; from the 4th strobe data_o=16'h8000, sat_o=0.
- osr_i=1, ds_i=0 constant -> strobes every 64 clocks with data_o=16'h0000; data_o stays 0 across all strobes.
- osr_i=2, ds_i repeating pattern 1,0,0,0 -> settled data_o=16'h4000 every 128 clocks. Change osr_i to 0 mid-period -> no strobe for the next 3*32 clocks, then data_o=16'h4000 every 32 clocks.
- Loopback: drive the delta-sigma modulator (mode 1, scale 0, osr 1) with a constant word 16'h6000 into ds_i -> settled data_o within ±2 LSB of 16'h6000 for 20 consecutive strobes.
- Assert rst_n_i asynchronously between clock edges mid-period -> data_o=0 and data_valid_o=0 immediately. After release, the first valid strobe appears at the 4th decimation event.
